// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I/M type definitions.
// Holds the M-extension funct3 encodings, the divide issue controller
// state type, the result record it broadcasts on the CDB, and small
// helpers that decode the divide-group funct3 values.
package rv32i_types;

  // M-extension funct3 encodings.
  typedef enum logic [2:0] {
    mult_div_f3_mul    = 3'b000,
    mult_div_f3_mulh   = 3'b001,
    mult_div_f3_mulhsu = 3'b010,
    mult_div_f3_mulhu  = 3'b011,
    mult_div_f3_div    = 3'b100,
    mult_div_f3_divu   = 3'b101,
    mult_div_f3_rem    = 3'b110,
    mult_div_f3_remu   = 3'b111
  } mult_div_f3_t;

  // Core-wide tag widths; the result record is sized to match them.
  localparam int CORE_PD_BITS  = 6;
  localparam int CORE_ROB_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } div_ctrl_state_t;

  typedef struct packed {
    logic [31:0]              rd_v;
    logic [CORE_PD_BITS-1:0]  pd;
    logic [CORE_ROB_BITS-1:0] rob_idx;
  } div_result_t;

  // div/rem are signed (funct3[0]==0); divu/remu are unsigned.
  function automatic logic div_is_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  // rem/remu return the remainder (funct3[1]==1).
  function automatic logic div_is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

  // Extend a 32-bit operand into the divider's 33-bit signed domain.
  function automatic logic [32:0] div_extend(input logic [31:0] v, input logic sgn);
    return {sgn & v[31], v};
  endfunction

endpackage

// File: rtl/div_special_case.sv
// div_special_case: combinational detection of the RISC-V divide special
// cases that are resolved without running the divider.
//   funct3         : divide-group funct3 of the request
//   rs1, rs2       : raw request operands
//   is_special     : op is divide-by-zero or signed overflow
//   special_result : architectural result for that case
module div_special_case
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        is_special,
  output logic [31:0] special_result
);

  always_comb begin
    is_special     = 1'b0;
    special_result = '0;
    if (funct3[2]) begin
      if (rs2 == 32'h0) begin
        // Divide by zero: quotient all ones, remainder is the dividend.
        is_special     = 1'b1;
        special_result = div_is_rem(funct3) ? rs1 : 32'hFFFF_FFFF;
      end else if (div_is_signed(funct3) && (rs1 == 32'h8000_0000) &&
                   (rs2 == 32'hFFFF_FFFF)) begin
        // Most-negative / -1 overflows: quotient wraps, remainder is 0.
        is_special     = 1'b1;
        special_result = div_is_rem(funct3) ? 32'h0 : 32'h8000_0000;
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/sequencing controller for the shared 33-bit
// iterative divider. Accepts one div/divu/rem/remu op at a time, resolves
// special cases locally, otherwise starts the divider and waits out its
// latency, then holds the tagged result on the CDB until granted.
//   req_*          : op from the MUL/DIV reservation station (valid/ready)
//   div_start/abort: divider control; div_a/div_b extended operands
//   div_complete, div_quotient, div_remainder : divider results
//   cdb_*          : result broadcast, held until cdb_grant
//   flush          : abort any in-flight op; busy : controller not idle
module div_issue_ctrl
  import rv32i_types::*;
#(
  parameter int PHYS_REG_BITS = CORE_PD_BITS,
  parameter int ROB_IDX_BITS  = CORE_ROB_BITS,
  parameter int DIV_CYCLES    = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_rs1_v,
  input  logic [31:0]              req_rs2_v,
  input  logic [PHYS_REG_BITS-1:0] req_pd,
  input  logic [ROB_IDX_BITS-1:0]  req_rob_idx,
  output logic                     div_start,
  output logic                     div_abort,
  output logic [32:0]              div_a,
  output logic [32:0]              div_b,
  input  logic                     div_complete,
  input  logic [32:0]              div_quotient,
  input  logic [32:0]              div_remainder,
  output logic                     cdb_valid,
  input  logic                     cdb_grant,
  output logic [31:0]              cdb_rd_v,
  output logic [PHYS_REG_BITS-1:0] cdb_pd,
  output logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
  output logic                     busy
);

  localparam int CNT_BITS = $clog2(DIV_CYCLES + 1);

  div_ctrl_state_t     state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic [2:0]          f3_reg, f3_next;
  logic [31:0]         rs1_reg, rs1_next;
  logic [31:0]         rs2_reg, rs2_next;
  div_result_t         result_reg, result_next;

  logic        is_special;
  logic [31:0] special_result;
  logic        accept;
  logic        in_divider;

  // Upper divider result bits carry only the sign extension.
  logic unused_bits;
  assign unused_bits = ^{div_quotient[32], div_remainder[32], f3_reg[2]};

  div_special_case u_special (
    .funct3         (req_funct3),
    .rs1            (req_rs1_v),
    .rs2            (req_rs2_v),
    .is_special     (is_special),
    .special_result (special_result)
  );

  assign accept     = req_valid && (state_reg == IDLE) && !flush && !rst;
  assign in_divider = (state_reg == START) || (state_reg == BUSY);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    f3_next     = f3_reg;
    rs1_next    = rs1_reg;
    rs2_next    = rs2_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          f3_next             = req_funct3;
          rs1_next            = req_rs1_v;
          rs2_next            = req_rs2_v;
          result_next.pd      = req_pd;
          result_next.rob_idx = req_rob_idx;
          if (is_special) begin
            result_next.rd_v = special_result;
            state_next       = DONE;
          end else begin
            state_next = START;
          end
        end
      end
      START: begin
        cnt_next   = CNT_BITS'(DIV_CYCLES - 1);
        state_next = BUSY;
      end
      BUSY: begin
        // The divider reports complete while idle, so complete is only
        // trusted once the minimum latency has elapsed.
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_BITS'(1);
        end else if (div_complete) begin
          result_next.rd_v = div_is_rem(f3_reg) ? div_remainder[31:0]
                                                : div_quotient[31:0];
          state_next       = DONE;
        end
      end
      DONE: begin
        if (cdb_grant) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Flush wins; a simultaneous grant in DONE still counts as broadcast.
    if (flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      f3_reg     <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      f3_reg     <= f3_next;
      rs1_reg    <= rs1_next;
      rs2_reg    <= rs2_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    busy        = 1'b0;
    div_start   = 1'b0;
    div_a       = '0;
    div_b       = '0;
    cdb_valid   = 1'b0;
    cdb_rd_v    = '0;
    cdb_pd      = '0;
    cdb_rob_idx = '0;
    // Abort also covers reset so the divider never survives a core reset.
    div_abort   = rst || (flush && in_divider);
    if (!rst) begin
      req_ready = (state_reg == IDLE);
      busy      = (state_reg != IDLE);
      div_start = (state_reg == START) && !flush;
      if (in_divider) begin
        div_a = div_extend(rs1_reg, div_is_signed(f3_reg));
        div_b = div_extend(rs2_reg, div_is_signed(f3_reg));
      end
      if (state_reg == DONE) begin
        cdb_valid   = 1'b1;
        cdb_rd_v    = result_reg.rd_v;
        cdb_pd      = result_reg.pd;
        cdb_rob_idx = result_reg.rob_idx;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench for div_issue_ctrl with a behavioural
// divider model and an expected-result scoreboard.
module tb_div_issue_ctrl;
  import rv32i_types::*;

  localparam int DIV_CYCLES = 34;
  localparam int NORM_LAT   = 2 + DIV_CYCLES;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1_v, req_rs2_v;
  logic [5:0]  req_pd;
  logic [4:0]  req_rob_idx;
  logic        div_start, div_abort, div_complete;
  logic [32:0] div_a, div_b, div_quotient, div_remainder;
  logic        cdb_valid, cdb_grant, busy;
  logic [31:0] cdb_rd_v;
  logic [5:0]  cdb_pd;
  logic [4:0]  cdb_rob_idx;

  always #5 clk = ~clk;

  div_issue_ctrl #(.PHYS_REG_BITS(6), .ROB_IDX_BITS(5), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1_v(req_rs1_v), .req_rs2_v(req_rs2_v), .req_pd(req_pd),
    .req_rob_idx(req_rob_idx),
    .div_start(div_start), .div_abort(div_abort), .div_a(div_a), .div_b(div_b),
    .div_complete(div_complete), .div_quotient(div_quotient),
    .div_remainder(div_remainder),
    .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_rd_v(cdb_rd_v),
    .cdb_pd(cdb_pd), .cdb_rob_idx(cdb_rob_idx), .busy(busy)
  );

  // Divider model: results valid DIV_CYCLES-1 cycles after the start pulse;
  // garbage on the data lines before that. In early_mode complete is
  // stuck high to expose any premature capture.
  logic [32:0]        m_a = '0, m_b = '0;
  int                 m_cnt = 0;
  logic               m_run = 1'b0;
  logic               early_mode = 1'b0;
  logic signed [32:0] sa, sb, sq, sr;
  logic               m_done;

  always_comb begin
    sa = m_a;
    sb = m_b;
    sq = '0;
    sr = '0;
    if (sb != 0) begin
      sq = sa / sb;
      sr = sa % sb;
    end
  end

  always @(posedge clk) begin
    if (div_abort) begin
      m_run <= 1'b0;
      m_cnt <= 0;
    end else if (div_start) begin
      m_a   <= div_a;
      m_b   <= div_b;
      m_cnt <= DIV_CYCLES - 1;
      m_run <= 1'b1;
    end else if (m_run && m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign m_done        = m_run && (m_cnt == 0);
  assign div_complete  = early_mode ? 1'b1 : (!m_run || m_done);
  assign div_quotient  = m_done ? sq : 33'h1_2345_6789;
  assign div_remainder = m_done ? sr : 33'h0_BAD0_BAD0;

  typedef struct {
    logic [31:0] rd;
    logic [5:0]  pd;
    logic [4:0]  rob;
  } exp_t;
  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic [5:0] pd, input logic [4:0] rob);
    exp_t e;
    e.rd  = rd;
    e.pd  = pd;
    e.rob = rob;
    sb_q.push_back(e);
  endtask

  // Present one op for one cycle; returns in the cycle after acceptance.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] pd, input logic [4:0] rob);
    chk({tag, "_ready"}, 64'(req_ready), 64'(1'b1));
    req_valid   = 1'b1;
    req_funct3  = f3;
    req_rs1_v   = a;
    req_rs2_v   = b;
    req_pd      = pd;
    req_rob_idx = rob;
    tick();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for cdb_valid, check latency and start-pulse count,
  // pop the scoreboard and compare; if granted, check the valid drops.
  task automatic wait_result(input string tag, input int exp_lat, input int exp_starts);
    int   lat    = 1;
    int   starts = 0;
    exp_t e;
    while (1) begin
      if (div_start) starts++;
      if (cdb_valid || lat >= 200) break;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_starts"}, 64'(starts), 64'(exp_starts));
    chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'(1'b1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rd_v"}, 64'(cdb_rd_v), 64'(e.rd));
      chk({tag, "_pd"}, 64'(cdb_pd), 64'(e.pd));
      chk({tag, "_rob"}, 64'(cdb_rob_idx), 64'(e.rob));
    end
    if (cdb_grant) begin
      tick();
      chk({tag, "_valid_drop"}, 64'(cdb_valid), 64'(1'b0));
      chk({tag, "_ready_after"}, 64'(req_ready), 64'(1'b1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_funct3 = '0;
    req_rs1_v = '0; req_rs2_v = '0; req_pd = '0; req_rob_idx = '0;
    cdb_grant = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'(1'b0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    chk("rst_div_abort", 64'(div_abort), 64'(1'b1));
    chk("rst_div_start", 64'(div_start), 64'(1'b0));
    rst = 1'b0;
    tick();
    chk("idle_req_ready", 64'(req_ready), 64'(1'b1));
    chk("idle_busy", 64'(busy), 64'(1'b0));
    chk("idle_div_a", 64'(div_a), 64'(33'h0));
    chk("idle_div_abort", 64'(div_abort), 64'(1'b0));

    cdb_grant = 1'b1;

    // div 100 / 7
    push(32'd14, 6'd3, 5'd1);
    issue("div100_7", mult_div_f3_div, 32'd100, 32'd7, 6'd3, 5'd1);
    chk("div100_7_start", 64'(div_start), 64'(1'b1));
    chk("div100_7_div_a", 64'(div_a), 64'(33'd100));
    chk("div100_7_div_b", 64'(div_b), 64'(33'd7));
    chk("div100_7_busy", 64'(busy), 64'(1'b1));
    wait_result("div100_7", NORM_LAT, 1);

    // rem -7 / 2 (signed) and remu same operands
    push(32'hFFFF_FFFF, 6'd4, 5'd2);
    issue("rem_m7_2", mult_div_f3_rem, 32'hFFFF_FFF9, 32'd2, 6'd4, 5'd2);
    chk("rem_m7_2_div_a", 64'(div_a), 64'(33'h1_FFFF_FFF9));
    chk("rem_m7_2_div_b", 64'(div_b), 64'(33'h0_0000_0002));
    wait_result("rem_m7_2", NORM_LAT, 1);

    push(32'd1, 6'd5, 5'd3);
    issue("remu_m7_2", mult_div_f3_remu, 32'hFFFF_FFF9, 32'd2, 6'd5, 5'd3);
    chk("remu_m7_2_div_a", 64'(div_a), 64'(33'h0_FFFF_FFF9));
    wait_result("remu_m7_2", NORM_LAT, 1);

    // Special cases resolved without the divider
    push(32'hFFFF_FFFF, 6'd6, 5'd4);
    issue("divu_5_0", mult_div_f3_divu, 32'd5, 32'd0, 6'd6, 5'd4);
    chk("divu_5_0_div_a", 64'(div_a), 64'(33'h0));
    wait_result("divu_5_0", 1, 0);

    push(32'd5, 6'd7, 5'd5);
    issue("remu_5_0", mult_div_f3_remu, 32'd5, 32'd0, 6'd7, 5'd5);
    wait_result("remu_5_0", 1, 0);

    push(32'h8000_0000, 6'd8, 5'd6);
    issue("div_ovf", mult_div_f3_div, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 5'd6);
    wait_result("div_ovf", 1, 0);

    push(32'h0, 6'd10, 5'd8);
    issue("rem_ovf", mult_div_f3_rem, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10, 5'd8);
    wait_result("rem_ovf", 1, 0);

    // Result held with grant low
    cdb_grant = 1'b0;
    push(32'd100, 6'd9, 5'd7);
    issue("hold", mult_div_f3_divu, 32'd1000, 32'd10, 6'd9, 5'd7);
    wait_result("hold", NORM_LAT, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 64'(cdb_valid), 64'(1'b1));
      chk("hold_rd_v", 64'(cdb_rd_v), 64'(32'd100));
      chk("hold_pd", 64'(cdb_pd), 64'(6'd9));
      chk("hold_rob", 64'(cdb_rob_idx), 64'(5'd7));
      chk("hold_ready", 64'(req_ready), 64'(1'b0));
    end
    // Grant cycle: a waiting request must not be accepted
    req_valid = 1'b1; req_funct3 = mult_div_f3_div; req_rs1_v = 32'd1; req_rs2_v = 32'd1;
    cdb_grant = 1'b1;
    #1;
    chk("grant_cycle_ready", 64'(req_ready), 64'(1'b0));
    tick();
    req_valid = 1'b0;
    chk("post_grant_valid", 64'(cdb_valid), 64'(1'b0));
    chk("post_grant_busy", 64'(busy), 64'(1'b0));
    chk("post_grant_ready", 64'(req_ready), 64'(1'b1));

    // Flush 5 cycles after start
    issue("flush_op", mult_div_f3_div, 32'd50, 32'd5, 6'd11, 5'd9);
    repeat (5) tick();
    flush = 1'b1;
    #1;
    chk("flush_abort", 64'(div_abort), 64'(1'b1));
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(1'b0));
    chk("flush_ready", 64'(req_ready), 64'(1'b1));
    chk("flush_abort_drop", 64'(div_abort), 64'(1'b0));
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      if (cdb_valid) seen++;
      tick();
    end
    chk("flush_no_cdb", 64'(seen), 64'(0));

    push(32'd3, 6'd12, 5'd10);
    issue("div9_3", mult_div_f3_div, 32'd9, 32'd3, 6'd12, 5'd10);
    wait_result("div9_3", NORM_LAT, 1);

    // Flush drops a same-cycle request
    req_valid = 1'b1; req_funct3 = mult_div_f3_div; req_rs1_v = 32'd8; req_rs2_v = 32'd2;
    flush = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush_drop_busy", 64'(busy), 64'(1'b0));
    chk("flush_drop_start", 64'(div_start), 64'(1'b0));

    // Divider reporting complete early must be ignored
    early_mode = 1'b1;
    push(32'd14, 6'd13, 5'd11);
    issue("early_cmpl", mult_div_f3_div, 32'd100, 32'd7, 6'd13, 5'd11);
    wait_result("early_cmpl", NORM_LAT, 1);
    early_mode = 1'b0;

    // Reset mid-operation
    issue("rst_op", mult_div_f3_div, 32'd20, 32'd4, 6'd14, 5'd12);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrst_abort", 64'(div_abort), 64'(1'b1));
    chk("midrst_ready", 64'(req_ready), 64'(1'b0));
    chk("midrst_div_a", 64'(div_a), 64'(33'h0));
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_after_ready", 64'(req_ready), 64'(1'b1));
    chk("midrst_after_busy", 64'(busy), 64'(1'b0));

    push(32'd5, 6'd15, 5'd13);
    issue("div20_4", mult_div_f3_div, 32'd20, 32'd4, 6'd15, 5'd13);
    wait_result("div20_4", NORM_LAT, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Sequencing controller that sits between the MUL/DIV reservation station and the shared iterative 33-bit sequential divider. It accepts one divide/remainder op at a time, sign- or zero-extends the operands, pulses the divider start, and waits out the divider latency. It resolves RISC-V special cases (divide-by-zero, signed overflow) without the divider, then holds the tagged result for the CDB until it is granted. A branch flush aborts any in-flight op.

Parameters:
PHYS_REG_BITS, 6, width of the destination physical register tag
ROB_IDX_BITS, 5, width of the ROB index tag
DIV_CYCLES, 34, minimum number of cycles after the start pulse before div_complete is trusted

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  global branch mispredict flush
req_valid  in  1  RS presents a div/rem op
req_ready  out  1  controller can accept an op this cycle
req_funct3  in  3  mult_div_f3_div/divu/rem/remu
req_rs1_v  in  32  dividend
req_rs2_v  in  32  divisor
req_pd  in  PHYS_REG_BITS  destination physical register
req_rob_idx  in  ROB_IDX_BITS  ROB tag
div_start  out  1  one-cycle start pulse to the divider
div_abort  out  1  resets the divider (OR'd into its reset)
div_a  out  33  extended dividend
div_b  out  33  extended divisor
div_complete  in  1  divider complete
div_quotient  in  33  divider quotient
div_remainder  in  33  divider remainder
cdb_valid  out  1  result pending broadcast
cdb_grant  in  1  CDB arbiter accepts the result
cdb_rd_v  out  32  result value
cdb_pd  out  PHYS_REG_BITS  result tag
cdb_rob_idx  out  ROB_IDX_BITS  result ROB index
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs are 0 while rst is high, including req_ready. Latched operands, tags and the counter are cleared.
- States: IDLE, START, BUSY, DONE. req_ready = (state==IDLE) && !rst.
- Accept when req_valid && req_ready && !flush. The controller latches funct3, rs1, rs2, pd and rob_idx.
  - If the op is a special case: next state DONE, result computed directly, no div_start.
  - Otherwise: next state START.
- Operand extension: div/rem sign-extend to bit 32; divu/remu zero-extend. div_a/div_b are driven from the latched operands and held constant from START through BUSY; they are 0 in IDLE and DONE.
- Special cases, detected on the request operands:
  - rs2==0: div/divu -> 0xFFFFFFFF; rem/remu -> rs1.
  - Signed op with rs1==0x80000000 and rs2==0xFFFFFFFF: div -> 0x80000000; rem -> 0.
- START: div_start=1 for exactly this cycle; counter loads DIV_CYCLES-1; next state BUSY.
- BUSY: counter decrements to 0 and saturates. While the counter is nonzero, div_complete is ignored (the divider reports complete while idle). When counter==0 and div_complete is high, capture quotient[31:0] (div/divu) or remainder[31:0] (rem/remu) into the result register; next state DONE. If complete is still low at that point, keep waiting.
- DONE: cdb_valid=1; cdb_rd_v, cdb_pd and cdb_rob_idx stay stable until cdb_grant. On grant the next state is IDLE. No new accept occurs in the grant cycle.
- Flush in any state: next state IDLE, cdb_valid low the next cycle, and any request in the same cycle is dropped.
  - If flush arrives in START or BUSY, div_abort=1 in that cycle.
  - If flush and cdb_grant are asserted together in DONE, the result counts as broadcast and the state returns to IDLE.
- Latency: normal op, accept at T, cdb_valid at T+2+DIV_CYCLES at the earliest. Special case: cdb_valid at T+1.
- rst mid-operation: same as flush plus a full register clear; div_abort=1 while rst is high.

Decomposition:
- rv32i_types already holds the mult_div_f3_* encodings. Add div_ctrl_state_t (IDLE/START/BUSY/DONE) and a div_result_t struct {rd_v, pd, rob_idx} to that package.
- One combinational sub-module, div_special_case. Inputs: funct3, rs1, rs2. Outputs: is_special, special_result.
- The FSM, counter and output register stay in div_issue_ctrl.

Test Plan:
- div 100 / 7 (signed) with a divider model and grant held high -> div_start one pulse, cdb_rd_v=14, cdb_valid for 1 cycle at accept+2+DIV_CYCLES.
- rem 0xFFFFFFF9 (-7) / 2 -> div_a=0x1FFFFFFF9, cdb_rd_v=0xFFFFFFFF. remu same operands -> div_a=0x0FFFFFFF9, cdb_rd_v=1.
- divu 5 / 0 -> no div_start, cdb_valid at accept+1 with 0xFFFFFFFF. remu 5 / 0 -> 5. div 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Result ready with grant held low 10 cycles -> cdb_valid and data/tags stable, req_ready=0. Grant -> IDLE, req_ready=1 the next cycle.
- Flush 5 cycles after start -> div_abort pulse, IDLE next cycle, no cdb_valid. A new op accepted afterwards completes correctly (div 9/3=3).
- div_complete held high during the first DIV_CYCLES-1 BUSY cycles -> no early capture.
